// File: rtl/genius_pkg.sv
`default_nettype none
// ============================================================================
// Module   : genius_pkg
// Purpose  : Shared types and constants for the Genius/Simon game core:
//            FSM state encoding, LFSR reset value and feedback taps, and the
//            width helpers used to size ports and counters.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package genius_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SHOW_ON  = 3'd2,
    SHOW_GAP = 3'd3,
    INPUT    = 3'd4,
    ADVANCE  = 3'd5,
    WIN      = 3'd6,
    LOSE     = 3'd7
  } state_e;

  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int lvl_width(input int m);
    return $clog2(m + 1);
  endfunction

  // Counter wide enough for the largest of the three tick budgets.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/genius_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : genius_lfsr
// Purpose  : 16-bit Galois LFSR used to generate the game sequence.
//            A load of seed 0 is replaced by LFSR_DEFAULT (an all-zero state
//            would lock up). load has priority over step.
// Ports    : clock, reset (sync, active-low)
//            load  - load seed this cycle
//            seed  - 16-bit seed value
//            step  - advance one position
//            symbol- current state modulo NUM_BTN
// Revision : 1.0 - initial release
// ============================================================================
module genius_lfsr
  import genius_pkg::*;
#(
  parameter int NUM_BTN = 4,
  parameter int IDX_W   = idx_width(NUM_BTN)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [15:0]      seed,
  input  logic             step,
  output logic [IDX_W-1:0] symbol
);

  localparam logic [15:0] NUM_BTN_W = 16'(NUM_BTN);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == 16'h0000) ? LFSR_DEFAULT : seed;
    end else if (step) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      lfsr_q <= LFSR_DEFAULT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign symbol = IDX_W'(lfsr_q % NUM_BTN_W);

endmodule
`default_nettype wire

// File: rtl/genius_engine.sv
`default_nettype none
// ============================================================================
// Module   : genius_engine
// Purpose  : Genius/Simon game core. Fills a sequence memory from a seeded
//            LFSR, shows a growing prefix of it one symbol per window, then
//            checks player presses against it with an input timeout.
// Ports    : clock, reset (sync, active-low)
//            tick        - timebase enable, all timing is in ticks
//            start       - begin a game from IDLE/WIN/LOSE
//            seed        - LFSR seed, sampled on the accepted start
//            btn         - one-cycle press pulses, one bit per button
//            show_valid  - a symbol is being displayed
//            show_symbol - displayed symbol index (0 when not showing)
//            level       - current sequence length
//            progress    - correct presses so far this round
//            busy        - game in progress
//            win / lose  - final status, held until start or reset
// Revision : 1.0 - initial release
// ============================================================================
module genius_engine
  import genius_pkg::*;
#(
  parameter  int NUM_BTN       = 4,
  parameter  int MAX_LEVEL     = 16,
  parameter  int SHOW_TICKS    = 4,
  parameter  int GAP_TICKS     = 1,
  parameter  int TIMEOUT_TICKS = 32,
  localparam int IDX_W         = idx_width(NUM_BTN),
  localparam int LVL_W         = lvl_width(MAX_LEVEL)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic [15:0]        seed,
  input  logic [NUM_BTN-1:0] btn,
  output logic               show_valid,
  output logic [IDX_W-1:0]   show_symbol,
  output logic [LVL_W-1:0]   level,
  output logic [LVL_W-1:0]   progress,
  output logic               busy,
  output logic               win,
  output logic               lose
);

  localparam int CNT_W = cnt_width(SHOW_TICKS, GAP_TICKS, TIMEOUT_TICKS);

  localparam logic [LVL_W-1:0] LAST_IDX     = LVL_W'(MAX_LEVEL - 1);
  localparam logic [LVL_W-1:0] MAX_LVL      = LVL_W'(MAX_LEVEL);
  localparam logic [LVL_W-1:0] ONE_LVL      = LVL_W'(1);
  localparam logic [CNT_W-1:0] SHOW_LAST    = CNT_W'(SHOW_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] ONE_CNT      = CNT_W'(1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   mem_q [MAX_LEVEL];
  logic [IDX_W-1:0]   mem_d [MAX_LEVEL];
  logic [LVL_W-1:0]   idx_q, idx_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [LVL_W-1:0]   progress_q, progress_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               show_valid_q, show_valid_d;
  logic [IDX_W-1:0]   show_symbol_q, show_symbol_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;
  logic               busy_q, busy_d;

  logic               lfsr_load;
  logic               lfsr_step;
  logic [IDX_W-1:0]   lfsr_sym;

  logic [LVL_W-1:0]   idx_next;
  logic [LVL_W-1:0]   prog_next;
  logic [IDX_W-1:0]   prog_sym;
  logic [IDX_W-1:0]   next_sym;
  logic [NUM_BTN-1:0] btn_expect;
  logic               gap_done;

  genius_lfsr #(
    .NUM_BTN (NUM_BTN),
    .IDX_W   (IDX_W)
  ) u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .load   (lfsr_load),
    .seed   (seed),
    .step   (lfsr_step),
    .symbol (lfsr_sym)
  );

  // Sequence memory reads, built as compare-and-select so the index width
  // need not match the memory depth.
  always_comb begin
    idx_next  = idx_q + ONE_LVL;
    prog_next = progress_q + ONE_LVL;
    prog_sym  = '0;
    next_sym  = '0;
    for (int i = 0; i < MAX_LEVEL; i++) begin
      if (progress_q == LVL_W'(i)) prog_sym = mem_q[i];
      if (idx_next == LVL_W'(i))   next_sym = mem_q[i];
    end
    // One-hot pattern of the only press that is accepted right now.
    btn_expect = '0;
    for (int b = 0; b < NUM_BTN; b++) begin
      btn_expect[b] = (prog_sym == IDX_W'(b));
    end
    // A zero-tick gap still occupies one cycle.
    gap_done = (GAP_TICKS == 0) || (tick && (cnt_q == GAP_LAST));
  end

  always_comb begin
    state_d       = state_q;
    mem_d         = mem_q;
    idx_d         = idx_q;
    level_d       = level_q;
    progress_d    = progress_q;
    cnt_d         = cnt_q;
    show_valid_d  = show_valid_q;
    show_symbol_d = show_symbol_q;
    win_d         = win_q;
    lose_d        = lose_q;
    lfsr_load     = 1'b0;
    lfsr_step     = 1'b0;

    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          state_d    = LOAD;
          lfsr_load  = 1'b1;
          level_d    = '0;
          progress_d = '0;
          idx_d      = '0;
          cnt_d      = '0;
          win_d      = 1'b0;
          lose_d     = 1'b0;
        end
      end

      LOAD: begin
        lfsr_step = 1'b1;
        for (int i = 0; i < MAX_LEVEL; i++) begin
          if (idx_q == LVL_W'(i)) mem_d[i] = lfsr_sym;
        end
        idx_d = idx_next;
        if (idx_q == LAST_IDX) begin
          // mem_d so that a single-entry sequence shows the value being
          // written this very cycle.
          state_d       = SHOW_ON;
          level_d       = ONE_LVL;
          idx_d         = '0;
          cnt_d         = '0;
          show_valid_d  = 1'b1;
          show_symbol_d = mem_d[0];
        end
      end

      SHOW_ON: begin
        if (tick) begin
          if (cnt_q == SHOW_LAST) begin
            state_d       = SHOW_GAP;
            cnt_d         = '0;
            show_valid_d  = 1'b0;
            show_symbol_d = '0;
          end else begin
            cnt_d = cnt_q + ONE_CNT;
          end
        end
      end

      SHOW_GAP: begin
        if (gap_done) begin
          cnt_d = '0;
          idx_d = idx_next;
          if (idx_next < level_q) begin
            state_d       = SHOW_ON;
            show_valid_d  = 1'b1;
            show_symbol_d = next_sym;
          end else begin
            state_d    = INPUT;
            progress_d = '0;
          end
        end else if (tick) begin
          cnt_d = cnt_q + ONE_CNT;
        end
      end

      INPUT: begin
        // A press outranks a simultaneous tick.
        if (btn != '0) begin
          if (btn == btn_expect) begin
            progress_d = prog_next;
            cnt_d      = '0;
            if (prog_next == level_q) state_d = ADVANCE;
          end else begin
            state_d = LOSE;
            lose_d  = 1'b1;
          end
        end else if (tick) begin
          if (cnt_q == TIMEOUT_LAST) begin
            state_d = LOSE;
            lose_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE_CNT;
          end
        end
      end

      ADVANCE: begin
        if (level_q == MAX_LVL) begin
          state_d = WIN;
          win_d   = 1'b1;
        end else begin
          state_d       = SHOW_ON;
          level_d       = level_q + ONE_LVL;
          idx_d         = '0;
          cnt_d         = '0;
          show_valid_d  = 1'b1;
          show_symbol_d = mem_d[0];
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = !(state_d inside {IDLE, WIN, LOSE});
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      mem_q         <= '{default: '0};
      idx_q         <= '0;
      level_q       <= '0;
      progress_q    <= '0;
      cnt_q         <= '0;
      show_valid_q  <= 1'b0;
      show_symbol_q <= '0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      idx_q         <= idx_d;
      level_q       <= level_d;
      progress_q    <= progress_d;
      cnt_q         <= cnt_d;
      show_valid_q  <= show_valid_d;
      show_symbol_q <= show_symbol_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
      busy_q        <= busy_d;
    end
  end

  assign show_valid  = show_valid_q;
  assign show_symbol = show_symbol_q;
  assign level       = level_q;
  assign progress    = progress_q;
  assign busy        = busy_q;
  assign win         = win_q;
  assign lose        = lose_q;

endmodule
`default_nettype wire

// File: tb/tb_genius_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_genius_engine
// Purpose  : Self-checking bench for genius_engine. A reference model derives
//            the symbol sequence from the seed; random seeds, wrong presses,
//            noise presses and tick patterns drive the game.
// Revision : 1.0 - initial release
// ============================================================================
module tb_genius_engine;

  localparam int NUM_BTN       = 4;
  localparam int MAX_LEVEL     = 3;
  localparam int SHOW_TICKS    = 4;
  localparam int GAP_TICKS     = 1;
  localparam int TIMEOUT_TICKS = 32;
  localparam int IDX_W         = 2;
  localparam int LVL_W         = 2;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               tick  = 1'b1;
  logic               start = 1'b0;
  logic [15:0]        seed  = 16'h0;
  logic [NUM_BTN-1:0] btn   = '0;
  logic               show_valid;
  logic [IDX_W-1:0]   show_symbol;
  logic [LVL_W-1:0]   level;
  logic [LVL_W-1:0]   progress;
  logic               busy;
  logic               win;
  logic               lose;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_seq [MAX_LEVEL];

  always #5 clock = ~clock;

  genius_engine #(
    .NUM_BTN       (NUM_BTN),
    .MAX_LEVEL     (MAX_LEVEL),
    .SHOW_TICKS    (SHOW_TICKS),
    .GAP_TICKS     (GAP_TICKS),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .start       (start),
    .seed        (seed),
    .btn         (btn),
    .show_valid  (show_valid),
    .show_symbol (show_symbol),
    .level       (level),
    .progress    (progress),
    .busy        (busy),
    .win         (win),
    .lose        (lose)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference sequence: symbol i is the generator state modulo NUM_BTN,
  // then the generator advances (divide by two, fold taps on a shifted-out 1).
  function automatic void build_seq(input int s_in);
    int s;
    int lsb;
    s = (s_in == 0) ? 'hACE1 : s_in;
    for (int i = 0; i < MAX_LEVEL; i++) begin
      exp_seq[i] = s % NUM_BTN;
      lsb = s % 2;
      s   = s / 2;
      if (lsb == 1) s = s ^ 'hB400;
    end
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic start_game(input int s);
    int n;
    seed  = 16'(s);
    start = 1'b1;
    build_seq(s);
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_level", level, 0);
    chk("start_win", win, 0);
    chk("start_lose", lose, 0);
    n = 1;
    while (!show_valid && n < 200) begin
      step();
      n++;
    end
    chk("load_len", n, MAX_LEVEL + 1);
    chk("load_level", level, 1);
  endtask

  task automatic show_round(input int lvl, input bit noisy);
    int cnt;
    tick = 1'b1;
    for (int k = 0; k < lvl; k++) begin
      chk("show_valid", show_valid, 1);
      chk("show_symbol", show_symbol, exp_seq[k]);
      chk("show_level", level, lvl);
      cnt = 0;
      while (show_valid && cnt < 50) begin
        if (noisy) btn = NUM_BTN'($urandom_range(1, 15));
        step();
        cnt++;
      end
      chk("show_len", cnt, SHOW_TICKS);
      chk("gap_blank", show_symbol, 0);
      if (k < lvl - 1) begin
        cnt = 0;
        while (!show_valid && cnt < 50) begin
          if (noisy) btn = NUM_BTN'($urandom_range(1, 15));
          step();
          cnt++;
        end
        chk("gap_len", cnt, GAP_TICKS);
      end else begin
        for (int g = 0; g < GAP_TICKS; g++) begin
          if (noisy) btn = NUM_BTN'($urandom_range(1, 15));
          step();
        end
        chk("input_blank", show_valid, 0);
        chk("input_busy", busy, 1);
      end
    end
    btn = '0;
  endtask

  task automatic press(input int sym);
    btn = NUM_BTN'(1 << sym);
    step();
    btn  = '0;
    tick = 1'b1;
  endtask

  // Lets exactly 31 ticks elapse in INPUT without a press.
  task automatic wait31();
    int t;
    int g;
    t = 0;
    g = 0;
    while (t < TIMEOUT_TICKS - 1 && g < 1000) begin
      tick = 1'($urandom_range(0, 1));
      step();
      t += int'(tick);
      g++;
    end
    chk("wait31_no_lose", lose, 0);
    tick = 1'b1;
  endtask

  task automatic play_input(input int lvl);
    int r;
    chk("input_progress0", progress, 0);
    for (int p = 0; p < lvl; p++) begin
      r = $urandom_range(0, 3);
      repeat (r) begin
        tick = 1'($urandom_range(0, 1));
        step();
        chk("idle_no_lose", lose, 0);
      end
      tick = 1'($urandom_range(0, 1));
      press(exp_seq[p]);
      chk("progress", progress, p + 1);
    end
    step();
    if (lvl < MAX_LEVEL) begin
      chk("next_level", level, lvl + 1);
      chk("next_show", show_valid, 1);
    end else begin
      chk("win", win, 1);
      chk("win_busy", busy, 0);
      chk("win_level", level, MAX_LEVEL);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    int w;
    int t;
    int g;

    // Reset held with start asserted.
    reset = 1'b0;
    start = 1'b1;
    seed  = 16'h0;
    repeat (3) step();
    chk("rst_show_valid", show_valid, 0);
    chk("rst_show_symbol", show_symbol, 0);
    chk("rst_level", level, 0);
    chk("rst_progress", progress, 0);
    chk("rst_busy", busy, 0);
    chk("rst_win", win, 0);
    chk("rst_lose", lose, 0);

    // Seed 0 behaves as 0xACE1; start stays high through the game start.
    build_seq('hACE1);
    reset = 1'b1;
    n = 0;
    while (!show_valid && n < 200) begin
      step();
      n++;
    end
    start = 1'b0;
    chk("rst_load_len", n, MAX_LEVEL + 1);
    chk("rst_load_level", level, 1);

    // Game A: full correct play to WIN.
    for (int lvl = 1; lvl <= MAX_LEVEL; lvl++) begin
      show_round(lvl, 1'b0);
      play_input(lvl);
    end
    repeat (4) begin
      btn = NUM_BTN'($urandom_range(1, 15));
      step();
      chk("win_hold", win, 1);
      chk("win_progress", progress, MAX_LEVEL);
      chk("win_level_hold", level, MAX_LEVEL);
    end
    btn = '0;

    // Game B: random seed, wrong single button at level 2.
    start_game(int'($urandom_range(1, 65535)));
    show_round(1, 1'b1);
    play_input(1);
    show_round(2, 1'b0);
    press(exp_seq[0]);
    chk("b_progress", progress, 1);
    w = (exp_seq[1] + $urandom_range(1, NUM_BTN - 1)) % NUM_BTN;
    press(w);
    chk("wrong_lose", lose, 1);
    chk("wrong_busy", busy, 0);
    chk("wrong_level", level, 2);
    chk("wrong_win", win, 0);
    repeat (3) begin
      btn = NUM_BTN'($urandom_range(1, 15));
      step();
      chk("lose_hold", lose, 1);
      chk("lose_progress", progress, 1);
    end
    btn = '0;

    // Game C: no press, lose exactly on the final allowed tick.
    start_game(int'($urandom_range(0, 65535)));
    show_round(1, 1'b0);
    t = 0;
    g = 0;
    while (t < TIMEOUT_TICKS && g < 1000) begin
      tick = 1'($urandom_range(0, 1));
      step();
      t += int'(tick);
      g++;
      if (t < TIMEOUT_TICKS) chk("to_no_lose", lose, 0);
    end
    chk("to_lose", lose, 1);
    chk("to_level", level, 1);
    tick = 1'b1;

    // Game D: presses right before timeout, start ignored while busy,
    // then a multi-bit press at level 3.
    start_game(int'($urandom_range(1, 65535)));
    show_round(1, 1'b1);
    wait31();
    press(exp_seq[0]);
    chk("d1_progress", progress, 1);
    chk("d1_lose", lose, 0);
    step();
    chk("d2_level", level, 2);
    start = 1'b1;
    show_round(2, 1'b1);
    start = 1'b0;
    wait31();
    press(exp_seq[0]);
    wait31();
    press(exp_seq[1]);
    chk("d2_progress", progress, 2);
    step();
    chk("d3_level", level, 3);
    show_round(3, 1'b0);
    btn = 4'b0011;
    step();
    btn = '0;
    chk("multi_lose", lose, 1);
    chk("multi_level", level, 3);
    chk("multi_progress", progress, 0);

    // Reset in mid-game aborts.
    start_game(int'($urandom_range(0, 65535)));
    step();
    reset = 1'b0;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_level", level, 0);
    chk("abort_show", show_valid, 0);
    chk("abort_lose", lose, 0);
    reset = 1'b1;
    step();
    chk("abort_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
